rep_iter_ctrl: RTL and testbench
================================

# rep_iter_ctrl

REP-prefix iteration sequencer for string instructions (MOVS/STOS/LODS/CMPS/SCAS). It latches the initial ECX count and REP flavour at instruction start. It issues one iteration at a time to the string execution unit through a valid/ready handshake, and decrements the count on each completed iteration. It terminates on count exhaustion or the REPE/REPNE ZF condition, writing each decremented count back to ECX. It sits between decode/dispatch and the string datapath, and uses the zero-detect comparator to test the count.

## Interface
- CNT_W, 32: count width; ECX width, always full 32-bit in this design
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-low; takes effect on the clk edge while low
- start  in  1  start request for a string instruction; accepted only when start_ready=1
- rep_type  in  2  REP flavour, sampled with start: 0 NONE, 1 REP, 2 REPE, 3 REPNE
- count_in  in  CNT_W  ECX value, sampled with start
- start_ready  out  1  controller idle and able to accept start
- iter_valid  out  1  request one string iteration
- iter_ready  in  1  string unit accepts iteration
- iter_done  in  1  one-cycle pulse: accepted iteration has completed
- iter_zf  in  1  ZF result of completed iteration; valid with iter_done; ignored for REP and NONE
- flush  in  1  pipeline flush; aborts any sequence
- ecx_out  out  CNT_W  decremented count for ECX writeback
- ecx_we  out  1  one-cycle ECX write enable
- busy  out  1  sequence in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse at sequence completion

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, DONE. Moore outputs are decoded from state. ecx_out/ecx_we are registered.
- IDLE: start_ready=1. On start, latch count_in into cnt and rep_type into rtype, then go to CHECK.
- CHECK: if rtype≠NONE and cnt==0, go to DONE with no iteration and no ECX write. Otherwise go to ISSUE.
- ISSUE: iter_valid=1. Hold until iter_ready=1, then go to WAIT. iter_valid stays high and does not drop while waiting.
- WAIT: wait for iter_done. On iter_done:
  - NONE: go to DONE with no count update.
  - Otherwise: cnt←cnt−1; ecx_out←cnt−1; ecx_we=1 next cycle.
  - Terminate to DONE if (cnt−1)==0, or rtype=REPE and iter_zf=0, or rtype=REPNE and iter_zf=1. Otherwise return to ISSUE; CHECK is not revisited.
- DONE: done=1 for one cycle, then go to IDLE.
- Decrement is modulo 2^CNT_W. Wrap cannot occur because zero is caught in CHECK.
- flush: from any state, go to IDLE next edge. No done, no ecx_we, and no iter_valid in the following cycle. flush with iter_done in the same cycle: flush wins and cnt is not written.
- start while not IDLE: ignored.
- clr low: state=IDLE, cnt=0, rtype=NONE, ecx_out=0, ecx_we=0, done=0. A sequence in progress is discarded.

## Timing
- Reset values: start_ready=1, iter_valid=0, ecx_out=0, ecx_we=0, busy=0, done=0.
- start accepted at edge T0 → CHECK during T0+1 → iter_valid high from T0+2 (if count≠0).
- iter_done at edge Tn → ecx_we/ecx_out valid during Tn+1. State is ISSUE (iter_valid=1) or DONE (done=1) during Tn+1.
- Zero count: start at T0 → done during T0+2, no iteration.
- Minimum per-iteration period: 2 cycles (ISSUE with immediate ready, then WAIT with same-cycle done impossible; iter_done is sampled only in WAIT).
- start_ready returns the cycle after done.

## Structure
- Shared package (pipeline-wide constants file): REP_NONE/REP/REPE/REPNE encodings and the state encoding for rep_iter_ctrl.
- Sub-module rep_count_dec: combinational cnt−1 plus zero-detect on cnt and cnt−1, built on equal_to_zero. The FSM and registers stay in rep_iter_ctrl using dff$-style library registers.

## Test plan
- REP, count_in=3, iter_ready tied 1 → three iterations; ecx_out 2,1,0 with one ecx_we each; done after third; total 3 iter_valid handshakes.
- REP, count_in=0 → no iter_valid, no ecx_we, done during T0+2.
- REPE, count_in=5, iter_zf=1,1,0 → terminates after 3rd iteration, ecx_out final=2, done.
- REPNE, count_in=4, iter_zf=0,1 → terminates after 2nd iteration, ecx_out final=2. NONE, count_in=0 → exactly one iteration, no ecx_we, done.
- REP, count_in=10, iter_ready held 0 for 4 cycles → iter_valid stays high; flush asserted same cycle as 2nd iter_done → IDLE, no ecx_we, no done, start_ready=1 next cycle.
- clr asserted low mid-WAIT → all outputs at reset values next cycle; new start with count_in=1 completes normally with ecx_out=0.

Source files
------------

// File: rtl/rep_iter_ctrl_pkg.sv
// Shared encodings for the REP string iteration sequencer.
package rep_iter_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        REP_NONE  = 2'd0,
        REP_REP   = 2'd1,
        REP_REPE  = 2'd2,
        REP_REPNE = 2'd3
    } rep_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } rep_state_e;

    // Zero comparator shared by every count test in the sequencer.
    function automatic logic equal_to_zero(input logic [CNT_W-1:0] val);
        return (val == '0);
    endfunction

endpackage

// File: rtl/rep_count_dec.sv
// Combinational count decrement with zero detect on the current and
// decremented count.
module rep_count_dec
    import rep_iter_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_dec,
    output logic             cnt_zero,
    output logic             dec_zero
);

    // Modulo decrement; wrap from zero is never consumed by the FSM.
    always_comb begin
        cnt_dec  = cnt - CNT_W'(1);
        cnt_zero = equal_to_zero(cnt);
        dec_zero = equal_to_zero(cnt_dec);
    end

endmodule

// File: rtl/rep_iter_ctrl.sv
// REP-prefix iteration sequencer: latches ECX and REP flavour, issues one
// string iteration at a time and writes each decremented count back.
//
// state | meaning
// IDLE  | waiting for start, start_ready=1
// CHECK | zero-count test on latched count
// ISSUE | iter_valid=1 until iter_ready
// WAIT  | waiting for iter_done, then decrement / terminate test
// DONE  | one-cycle done pulse
module rep_iter_ctrl
    import rep_iter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       rep_type,
    input  logic [CNT_W-1:0] count_in,
    output logic             start_ready,
    output logic             iter_valid,
    input  logic             iter_ready,
    input  logic             iter_done,
    input  logic             iter_zf,
    input  logic             flush,
    output logic [CNT_W-1:0] ecx_out,
    output logic             ecx_we,
    output logic             busy,
    output logic             done
);

    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rep_type_e        rtype_q, rtype_d;
    logic [CNT_W-1:0] ecx_out_q, ecx_out_d;
    logic             ecx_we_q, ecx_we_d;

    logic [CNT_W-1:0] cnt_dec;
    logic             cnt_zero;
    logic             dec_zero;
    logic             zf_stop;

    rep_count_dec u_count_dec (
        .cnt      (cnt_q),
        .cnt_dec  (cnt_dec),
        .cnt_zero (cnt_zero),
        .dec_zero (dec_zero)
    );

    // Register all sequencer state; clr discards any sequence in progress.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rtype_q   <= REP_NONE;
            ecx_out_q <= '0;
            ecx_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rtype_q   <= rtype_d;
            ecx_out_q <= ecx_out_d;
            ecx_we_q  <= ecx_we_d;
        end
    end

    // REPE stops on ZF=0, REPNE stops on ZF=1; plain REP ignores ZF.
    always_comb begin
        zf_stop = 1'b0;
        case (rtype_q)
            REP_REPE:  zf_stop = ~iter_zf;
            REP_REPNE: zf_stop = iter_zf;
            default:   zf_stop = 1'b0;
        endcase
    end

    // Next-state, count update and writeback; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rtype_d   = rtype_q;
        ecx_out_d = ecx_out_q;
        ecx_we_d  = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_d   = count_in;
                        rtype_d = rep_type_e'(rep_type);
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rtype_q != REP_NONE && cnt_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (iter_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (iter_done) begin
                        if (rtype_q == REP_NONE) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d     = cnt_dec;
                            ecx_out_d = cnt_dec;
                            ecx_we_d  = 1'b1;
                            if (dec_zero || zf_stop) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_ISSUE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state; writeback comes straight from flops.
    always_comb begin
        start_ready = (state_q == ST_IDLE);
        iter_valid  = (state_q == ST_ISSUE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        ecx_out     = ecx_out_q;
        ecx_we      = ecx_we_q;
    end

endmodule

// File: tb/tb_rep_iter_ctrl.sv
// Directed bench for rep_iter_ctrl.
module tb_rep_iter_ctrl;

    logic        clk;
    logic        clr;
    logic        start;
    logic [1:0]  rep_type;
    logic [31:0] count_in;
    logic        start_ready;
    logic        iter_valid;
    logic        iter_ready;
    logic        iter_done;
    logic        iter_zf;
    logic        flush;
    logic [31:0] ecx_out;
    logic        ecx_we;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;
    int hs_cnt;
    int hs_base;

    rep_iter_ctrl dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .rep_type    (rep_type),
        .count_in    (count_in),
        .start_ready (start_ready),
        .iter_valid  (iter_valid),
        .iter_ready  (iter_ready),
        .iter_done   (iter_done),
        .iter_zf     (iter_zf),
        .flush       (flush),
        .ecx_out     (ecx_out),
        .ecx_we      (ecx_we),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (iter_valid === 1'b1 && iter_ready === 1'b1) hs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected Moore outputs plus writeback in the current cycle.
    task automatic chk_out(input string tag, input logic e_sr, input logic e_iv,
                           input logic e_busy, input logic e_done,
                           input logic e_we, input logic [31:0] e_ecx);
        chk({tag, ".start_ready"}, 32'(start_ready), 32'(e_sr));
        chk({tag, ".iter_valid"},  32'(iter_valid),  32'(e_iv));
        chk({tag, ".busy"},        32'(busy),        32'(e_busy));
        chk({tag, ".done"},        32'(done),        32'(e_done));
        chk({tag, ".ecx_we"},      32'(ecx_we),      32'(e_we));
        chk({tag, ".ecx_out"},     ecx_out,          e_ecx);
    endtask

    task automatic do_start(input logic [1:0] rt, input logic [31:0] cnt);
        start    = 1'b1;
        rep_type = rt;
        count_in = cnt;
        tick();
        start    = 1'b0;
        count_in = 32'hdead_beef;
    endtask

    // From ISSUE with iter_ready=1: accept, then complete with given ZF.
    task automatic do_iter(input string tag, input logic zf, input logic last,
                           input logic e_we, input logic [31:0] e_ecx);
        tick();
        chk_out({tag, ".wait"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ecx_out);
        iter_done = 1'b1;
        iter_zf   = zf;
        tick();
        iter_done = 1'b0;
        iter_zf   = 1'b0;
        chk_out({tag, ".post"}, 1'b0, ~last, 1'b1, last, e_we, e_ecx);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; hs_cnt = 0;
        clr = 1'b0; start = 1'b0; rep_type = 2'd0; count_in = '0;
        iter_ready = 1'b0; iter_done = 1'b0; iter_zf = 1'b0; flush = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        clr = 1'b1;
        tick();

        // REP, count 3, ready tied high
        iter_ready = 1'b1;
        hs_base = hs_cnt;
        do_start(2'd1, 32'd3);
        chk_out("rep3.check", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        chk_out("rep3.issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        do_iter("rep3.i1", 1'b0, 1'b0, 1'b1, 32'd2);
        do_iter("rep3.i2", 1'b0, 1'b0, 1'b1, 32'd1);
        do_iter("rep3.i3", 1'b0, 1'b1, 1'b1, 32'd0);
        tick();
        chk_out("rep3.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rep3.handshakes", 32'(hs_cnt - hs_base), 32'd3);

        // REP, count 0: done at T0+2 with no iteration
        hs_base = hs_cnt;
        do_start(2'd1, 32'd0);
        chk_out("rep0.check", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        chk_out("rep0.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        chk_out("rep0.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rep0.handshakes", 32'(hs_cnt - hs_base), 32'd0);

        // REPE, count 5, ZF 1,1,0
        do_start(2'd2, 32'd5);
        tick();
        chk_out("repe.issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        do_iter("repe.i1", 1'b1, 1'b0, 1'b1, 32'd4);
        do_iter("repe.i2", 1'b1, 1'b0, 1'b1, 32'd3);
        do_iter("repe.i3", 1'b0, 1'b1, 1'b1, 32'd2);
        tick();
        chk_out("repe.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);

        // REPNE, count 4, ZF 0,1; a start held high while busy is ignored
        do_start(2'd3, 32'd4);
        start = 1'b1;
        count_in = 32'd77;
        tick();
        do_iter("repne.i1", 1'b0, 1'b0, 1'b1, 32'd3);
        start = 1'b0;
        do_iter("repne.i2", 1'b1, 1'b1, 1'b1, 32'd2);
        tick();
        chk_out("repne.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);

        // NONE, count 0: exactly one iteration, no writeback
        hs_base = hs_cnt;
        do_start(2'd0, 32'd0);
        tick();
        chk_out("none.issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
        do_iter("none.i1", 1'b1, 1'b1, 1'b0, 32'd2);
        tick();
        chk_out("none.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        chk("none.handshakes", 32'(hs_cnt - hs_base), 32'd1);

        // REP, count 10, ready held low then flush with 2nd iter_done
        iter_ready = 1'b0;
        do_start(2'd1, 32'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out("flush.hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
            tick();
        end
        iter_ready = 1'b1;
        do_iter("flush.i1", 1'b0, 1'b0, 1'b1, 32'd9);
        tick();
        chk_out("flush.wait2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd9);
        iter_done = 1'b1;
        flush     = 1'b1;
        tick();
        iter_done = 1'b0;
        flush     = 1'b0;
        chk_out("flush.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9);
        tick();
        chk_out("flush.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9);

        // clr low mid-WAIT, then a fresh count-1 sequence
        do_start(2'd1, 32'd7);
        tick();
        do_iter("clr.i1", 1'b0, 1'b0, 1'b1, 32'd6);
        tick();
        chk_out("clr.wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6);
        clr = 1'b0;
        iter_done = 1'b1;
        tick();
        clr = 1'b1;
        iter_done = 1'b0;
        chk_out("clr.reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_start(2'd1, 32'd1);
        chk_out("clr.check", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        chk_out("clr.issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        do_iter("clr.n1", 1'b0, 1'b1, 1'b1, 32'd0);
        tick();
        chk_out("clr.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
